// File: rtl/ibus_responder_pkg.sv
// ibus_responder_pkg: shared Avalon instruction-bus types and constants
package ibus_responder_pkg;
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef struct packed {
    logic        read;
    logic        write;
    logic [31:0] address;
    logic [31:0] writedata;
    logic [3:0]  byte_enable;
  } avalon_req_t;
  typedef struct packed {
    logic [31:0] readdata;
    logic        waitrequest;
    logic        readdatavalid;
  } avalon_resp_t;
endpackage

// File: rtl/ibus_ram.sv
// ibus_ram: byte-writable word RAM with a one-cycle synchronous read port
module ibus_ram #(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;
  // no reset here: memory contents must survive rst
  always_ff @(posedge clk) begin
    rdata_q <= mem_q[addr];
    for (int b = 0; b < 4; b++) if (we && be[b]) mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/ibus_responder.sv
// ibus_responder: Avalon-MM instruction memory slave with fixed-latency pipelined reads
module ibus_responder
  import ibus_responder_pkg::*;
#(
  parameter int MEM_DEPTH       = 4096,
  parameter int READ_LATENCY    = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  avalon_req_t  ibus_avalon_req,
  output avalon_resp_t ibus_avalon_resp,
  output logic         addr_err
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PL = READ_LATENCY - 1;
  localparam logic [CW-1:0] CMAX = CW'(MAX_OUTSTANDING);
  logic [CW-1:0] cnt_q, cnt_d;
  logic s0_v_q, s0_v_d, oor_q, oor_d;
  logic [31:0] hold_q, hold_d;
  logic wait_req, acc, rd_acc, wr_acc, oor, out_v;
  logic [31:0] ram_rdata, s0_data, out_d;
  logic unused_ok;
  assign unused_ok = ^ibus_avalon_req.address[1:0];
  // accept, decode and outstanding-count bookkeeping; read wins over a simultaneous write
  always_comb begin
    oor = |ibus_avalon_req.address[31:AW+2];
    wait_req = (cnt_q == CMAX) && !out_v;
    acc = rst && (ibus_avalon_req.read || ibus_avalon_req.write) && !wait_req;
    rd_acc = acc && ibus_avalon_req.read;
    wr_acc = acc && ibus_avalon_req.write && !ibus_avalon_req.read && !oor;
    cnt_d = (rd_acc && !out_v) ? cnt_q + CW'(1) : (!rd_acc && out_v) ? cnt_q - CW'(1) : cnt_q;
    s0_v_d = rd_acc;
    oor_d = oor;
  end
  // out-of-range reads return NOP instead of aliased RAM data
  always_comb s0_data = oor_q ? NOP : ram_rdata;
  // readdata holds the last returned beat between beats
  always_comb hold_d = out_v ? out_d : hold_q;
  ibus_ram #(.DEPTH(MEM_DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (wr_acc),
    .be   (ibus_avalon_req.byte_enable),
    .addr (ibus_avalon_req.address[AW+1:2]),
    .wdata(ibus_avalon_req.writedata),
    .rdata(ram_rdata)
  );
  // stage-0 tracking alongside the RAM read register, plus counter and hold register
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q <= '0;
      s0_v_q <= 1'b0;
      oor_q <= 1'b0;
      hold_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      s0_v_q <= s0_v_d;
      oor_q <= oor_d;
      hold_q <= hold_d;
    end
  if (PL > 0) begin : g_pipe
    logic [PL-1:0] v_q, v_d;
    logic [31:0] d_q [PL];
    logic [31:0] d_d [PL];
    // remaining latency stages behind the RAM register
    always_comb begin
      v_d[0] = s0_v_q;
      d_d[0] = s0_data;
      for (int i = 1; i < PL; i++) begin
        v_d[i] = v_q[i-1];
        d_d[i] = d_q[i-1];
      end
    end
    // reset drops any read in flight
    always_ff @(posedge clk or negedge rst)
      if (!rst) begin
        v_q <= '0;
        d_q <= '{default: '0};
      end else begin
        v_q <= v_d;
        d_q <= d_d;
      end
    assign out_v = v_q[PL-1];
    assign out_d = d_q[PL-1];
  end else begin : g_nopipe
    assign out_v = s0_v_q;
    assign out_d = s0_data;
  end
  // response and error outputs
  always_comb begin
    ibus_avalon_resp.readdata = out_v ? out_d : hold_q;
    ibus_avalon_resp.waitrequest = wait_req;
    ibus_avalon_resp.readdatavalid = out_v;
    addr_err = acc && oor;
  end
endmodule

// File: tb/tb_ibus_responder.sv
// tb_ibus_responder: directed self-checking bench for ibus_responder
module tb_ibus_responder;
  import ibus_responder_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  avalon_req_t a_req, b_req;
  avalon_resp_t a_resp, b_resp;
  logic a_err, b_err;
  int checks = 0;
  int failures = 0;
  logic [31:0] exp4 [4];

  always #5 clk = ~clk;

  ibus_responder ua (.clk(clk), .rst(rst), .ibus_avalon_req(a_req), .ibus_avalon_resp(a_resp), .addr_err(a_err));
  ibus_responder #(.READ_LATENCY(3), .MAX_OUTSTANDING(1)) ub (
    .clk(clk), .rst(rst), .ibus_avalon_req(b_req), .ibus_avalon_resp(b_resp), .addr_err(b_err));

  function automatic avalon_req_t rq(input logic rd, input logic wr, input logic [31:0] ad,
                                     input logic [31:0] wd, input logic [3:0] be);
    avalon_req_t r;
    r.read = rd;
    r.write = wr;
    r.address = ad;
    r.writedata = wd;
    r.byte_enable = be;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] be);
    a_req = rq(1'b0, 1'b1, ad, wd, be);
    @(negedge clk);
    next;
  endtask

  task automatic a_read_chk(input string tag, input logic [31:0] ad, input logic [31:0] exp);
    a_req = rq(1'b1, 1'b0, ad, 0, 0);
    @(negedge clk);
    chk({tag, "_wait"}, 32'(a_resp.waitrequest), 0);
    chk({tag, "_err"}, 32'(a_err), 0);
    next;
    a_req = '0;
    @(negedge clk);
    chk({tag, "_early"}, 32'(a_resp.readdatavalid), 0);
    next;
    @(negedge clk);
    chk({tag, "_valid"}, 32'(a_resp.readdatavalid), 1);
    chk({tag, "_data"}, a_resp.readdata, exp);
    next;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

  initial begin
    exp4 = '{32'h00500093, 32'h11111111, 32'h22222222, 32'h33333333};
    b_req = '0;
    a_req = rq(1'b1, 1'b0, 32'h4000, 0, 0);
    @(negedge clk);
    chk("rst_valid", 32'(a_resp.readdatavalid), 0);
    chk("rst_data", a_resp.readdata, 0);
    chk("rst_wait", 32'(a_resp.waitrequest), 0);
    chk("rst_err", 32'(a_err), 0);
    chk("rst_cnt", 32'(ua.cnt_q), 0);
    next;
    rst = 1'b1;
    a_req = '0;
    next;
    a_write(32'h0, 32'h00500093, 4'hF);
    a_read_chk("r0", 32'h0, 32'h00500093);
    @(negedge clk);
    chk("r0_after", 32'(a_resp.readdatavalid), 0);
    chk("r0_hold", a_resp.readdata, 32'h00500093);
    next;
    a_write(32'h4, 32'h11111111, 4'hF);
    a_write(32'h8, 32'h22222222, 4'hF);
    a_write(32'hC, 32'h33333333, 4'hF);
    for (int k = 0; k < 6; k++) begin
      a_req = rq(k < 4, 1'b0, 32'(k * 4 + ((k == 1) ? 2 : 0)), 0, 0);
      @(negedge clk);
      if (k < 4) chk("b2b_wait", 32'(a_resp.waitrequest), 0);
      if (k == 3) chk("b2b_cnt", 32'(ua.cnt_q), 2);
      chk("b2b_valid", 32'(a_resp.readdatavalid), 32'(k >= 2));
      if (k >= 2) chk("b2b_data", a_resp.readdata, exp4[k-2]);
      next;
    end
    a_write(32'h10, 32'h11223344, 4'hF);
    a_write(32'h10, 32'hDEADBEEF, 4'b0011);
    a_read_chk("be", 32'h10, 32'h1122BEEF);
    a_req = rq(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 4'hF);
    @(negedge clk);
    next;
    a_req = '0;
    next;
    @(negedge clk);
    chk("rw_valid", 32'(a_resp.readdatavalid), 1);
    chk("rw_data", a_resp.readdata, 32'h1122BEEF);
    next;
    a_read_chk("rw_after", 32'h10, 32'h1122BEEF);
    a_req = rq(1'b1, 1'b0, 32'h4000, 0, 0);
    @(negedge clk);
    chk("oor_err", 32'(a_err), 1);
    next;
    a_req = '0;
    @(negedge clk);
    chk("oor_err_pulse", 32'(a_err), 0);
    chk("oor_early", 32'(a_resp.readdatavalid), 0);
    next;
    @(negedge clk);
    chk("oor_valid", 32'(a_resp.readdatavalid), 1);
    chk("oor_data", a_resp.readdata, NOP);
    next;
    a_req = rq(1'b0, 1'b1, 32'h4010, 32'h0, 4'hF);
    @(negedge clk);
    chk("oorw_err", 32'(a_err), 1);
    next;
    a_read_chk("oorw_drop", 32'h10, 32'h1122BEEF);
    a_req = rq(1'b1, 1'b0, 32'h0, 0, 0);
    next;
    a_req = rq(1'b1, 1'b0, 32'h4, 0, 0);
    next;
    a_req = '0;
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(a_resp.readdatavalid), 0);
    chk("mid_rst_data", a_resp.readdata, 0);
    chk("mid_rst_cnt", 32'(ua.cnt_q), 0);
    next;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_valid", 32'(a_resp.readdatavalid), 0);
      next;
    end
    a_read_chk("post_rst", 32'h0, 32'h00500093);
    b_req = rq(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
    next;
    for (int k = 0; k < 11; k++) begin
      b_req = rq(k < 9, 1'b0, 32'h0, 0, 0);
      @(negedge clk);
      chk("mo1_wait", 32'(b_resp.waitrequest), 32'(k < 9 && k % 3 != 0));
      chk("mo1_valid", 32'(b_resp.readdatavalid), 32'(k >= 3 && k % 3 == 0));
      if (k >= 3 && k % 3 == 0) chk("mo1_data", b_resp.readdata, 32'hCAFEF00D);
      next;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ibus_responder.md
IBUS_RESPONDER -- requirements
Module: ibus_responder

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 4096, meaning the number of 32-bit words in the instruction memory (power of two).
REQ-002 SHALL have parameter READ_LATENCY, default 2, meaning the number of cycles from accepted read to readdatavalid (legal range 1-4).
REQ-003 SHALL have parameter MAX_OUTSTANDING, default 4, meaning the maximum number of accepted reads whose data has not yet returned (legal range 1-8).
REQ-004 SHALL have the following ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst  input  1  reset, asynchronous assert, active-low.
- ibus_avalon_req  input  avalon_req_t  instruction bus request: read, write, address (byte address), writedata, byte_enable.
- ibus_avalon_resp  output  avalon_resp_t  instruction bus response: readdata, waitrequest, readdatavalid.
- addr_err  output  1  one-cycle pulse when an accepted access addresses beyond MEM_DEPTH words.

Function
REQ-005 SHALL accept a request in any cycle where (read or write) is high and waitrequest is low.
REQ-006 SHALL drive waitrequest combinationally high when outstanding count == MAX_OUTSTANDING and no readdatavalid is issued in the same cycle; otherwise low.
REQ-007 SHALL decode the word index as address[log2(MEM_DEPTH)+1:2] and ignore address[1:0].
REQ-008 SHALL return readdata with readdatavalid high exactly READ_LATENCY cycles after acceptance, one beat per accepted read, in acceptance order.
REQ-009 SHALL sustain one accepted read per cycle (back-to-back) when MAX_OUTSTANDING >= READ_LATENCY.
REQ-010 SHALL keep an outstanding counter (width clog2(MAX_OUTSTANDING+1)): +1 on accepted read, -1 on readdatavalid, unchanged when both occur in the same cycle.
REQ-011 SHALL perform an accepted write in the acceptance cycle, updating only the bytes selected by byte_enable; writes produce no readdatavalid and do not change the outstanding counter.
REQ-012 SHALL return, for a read in the same cycle as or after a write to the same word, the newly written data (write-before-read ordering).
REQ-013 SHALL, for an out-of-range access, drop a write, return readdata = 32'h0000_0013 (NOP) with normal latency for a read, and pulse addr_err in the acceptance cycle.
REQ-014 SHALL treat read and write asserted together as a read only, with the write dropped.
REQ-015 SHALL hold readdata stable at the last returned value while readdatavalid is low.

Reset
REQ-016 SHALL, on rst low, clear the outstanding counter, the latency pipeline valid bits, readdatavalid, addr_err, and readdata (to 0) asynchronously; waitrequest SHALL read 0 during and after reset.
REQ-017 SHALL discard reads in flight when reset is asserted mid-operation; no readdatavalid SHALL follow for them.
REQ-018 SHALL NOT clear memory contents on reset.

Structure
REQ-019 SHALL use avalon_req_t and avalon_resp_t from the shared core package/header; the NOP constant SHALL also live there.
REQ-020 SHALL place the byte-writable RAM array in one sub-module, ibus_ram, with a one-cycle synchronous read; the remaining READ_LATENCY-1 stages SHALL be a valid/data shift pipeline in ibus_responder.

Verification
REQ-021 Reset, then read at address 0x0 after preload word0=0x00500093 -> readdatavalid high in cycle 2 after acceptance with readdata 0x00500093.
REQ-022 Four back-to-back reads at 0x0, 0x4, 0x8, 0xC (defaults) -> four consecutive readdatavalid beats in order and waitrequest never asserted.
REQ-023 MAX_OUTSTANDING=1, READ_LATENCY=3, continuous read -> waitrequest high for 2 of every 3 cycles and one beat every 3 cycles.
REQ-024 Write 0xDEADBEEF with byte_enable=4'b0011 to 0x10 holding 0x11223344, then read 0x10 -> readdata 0x1122BEEF.
REQ-025 Read at byte address 4*MEM_DEPTH -> addr_err pulses once; readdata 0x00000013 returned after READ_LATENCY cycles.
REQ-026 Assert rst with 2 reads in flight -> no readdatavalid after reset release; counter 0; next read accepted immediately.
